sm3_pad_core: RTL
=================

SM3_PAD_CORE -- requirements
Module: sm3_pad_core

Interface
REQ-001 The block SHALL have no parameters; word width is fixed at 32 bits and the length field at 64 bits.
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 msin_d_i  input  32  message word, big-endian (first byte in [31:24]).
REQ-005 msin_vld_i  input  1  message word valid.
REQ-006 msin_lst_i  input  1  word is the last word of the message.
REQ-007 msin_bcnt_i  input  2  valid bytes in the last word: 0=4, 1..3=1..3; ignored when msin_lst_i=0.
REQ-008 msin_rdy_o  output  1  block accepts msin word (transfer = vld & rdy).
REQ-009 pad_otpt_d_o  output  32  padded word to the expansion core.
REQ-010 pad_otpt_vld_o  output  1  pad_otpt_d_o valid.
REQ-011 pad_otpt_lst_o  output  1  word 15 of the final 512-bit block of the message.
REQ-012 pad_otpt_ena_i  input  1  downstream ready (transfer = vld & ena).

Function
REQ-013 The output SHALL be a single register stage: a word accepted on msin appears on pad_otpt one cycle later.
REQ-014 The output register SHALL load only when empty or when transferring this cycle; while vld=1 and ena=0, d/vld/lst SHALL hold stable.
REQ-015 msin_rdy_o SHALL be 1 only in state DATA and when (!pad_otpt_vld_o | pad_otpt_ena_i); msin_vld_i in any other state SHALL be ignored.
REQ-016 FSM states SHALL be DATA, PAD_ONE, PAD_ZERO, LEN_HI, LEN_LO; reset state DATA.
REQ-017 A 4-bit word index SHALL count output words 0..15 within a block, incrementing on each output load and wrapping 15->0.
REQ-018 A 64-bit bit counter SHALL add 32 per non-last word and 32 or 8*bcnt for the last word; it SHALL wrap modulo 2^64.
REQ-019 DATA, non-last word: output msin_d_i unchanged.
REQ-020 DATA, last word bcnt=1/2/3: output {d[31:24],80h,0000h} / {d[31:16],80h,00h} / {d[31:8],80h}; next state PAD_ZERO, or LEN_HI if that word had index 13.
REQ-021 DATA, last word bcnt=0: output d unchanged; next state PAD_ONE.
REQ-022 PAD_ONE: output 80000000h; next PAD_ZERO, or LEN_HI if that word had index 13.
REQ-023 PAD_ZERO: output 0; leave for LEN_HI after the word at index 13 is loaded; if padding began at index 14 or 15, zeros SHALL continue through the next block's index 13.
REQ-024 LEN_HI at index 14 outputs bitcnt[63:32]; LEN_LO at index 15 outputs bitcnt[31:0] with pad_otpt_lst_o=1, then returns to DATA.
REQ-025 Returning to DATA SHALL clear the bit counter; the index is then 0. Back-to-back messages SHALL need no idle cycle beyond the single register stage.
REQ-026 pad_otpt_lst_o SHALL be 0 on every word except LEN_LO.
REQ-027 Zero-length messages are unsupported: a lst word carries at least 1 byte.

Reset
REQ-028 With rst=1 at a clock edge: pad_otpt_vld_o=0, pad_otpt_lst_o=0, pad_otpt_d_o=0, msin_rdy_o=0, state=DATA, index=0, bitcnt=0.
REQ-029 Reset in any state, mid-block or mid-stall, SHALL discard the message in flight; msin_rdy_o=1 on the first cycle after rst deasserts.

Verification
REQ-030 "abc": one word 61626300h, lst, bcnt=3 -> 16 words 61626380h, 14 x 0, 00000018h; lst only on the 16th.
REQ-031 16 words 61626364h, bcnt=0 on the 16th -> block 1 the 16 data words; block 2 80000000h, 14 x 0, 00000200h; lst on word 32 only.
REQ-032 14 full words, last bcnt=0 -> 14 data words, 80000000h at index 14, 0 at index 15, then 14 zeros, 0, 000001C0h; 32 words total.
REQ-033 Backpressure: "abc" case with ena held 0 for 5 cycles at index 3, then toggled randomly -> identical 16-word sequence; held word stable; no drop or duplicate.
REQ-034 rst pulsed for 1 cycle during PAD_ZERO -> vld=0 next cycle; a following "abc" message reproduces REQ-030 exactly.
REQ-035 Two back-to-back messages ("abc", then 61h bcnt=1) -> second block ends 00000008h; the first message's length does not carry over.

Source files
------------

// File: rtl/sm3_pad_core.sv
// SM3 message padder: streams 32-bit big-endian message words and emits the padded
// 512-bit blocks (data, 0x80 marker, zero fill, 64-bit bit length) one word per cycle.
module sm3_pad_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] msin_d_i,
   input  logic        msin_vld_i,
   input  logic        msin_lst_i,
   input  logic [1:0]  msin_bcnt_i,
   output logic        msin_rdy_o,
   output logic [31:0] pad_otpt_d_o,
   output logic        pad_otpt_vld_o,
   output logic        pad_otpt_lst_o,
   input  logic        pad_otpt_ena_i
);

   localparam logic [2:0] DATA     = 3'd0;
   localparam logic [2:0] PAD_ONE  = 3'd1;
   localparam logic [2:0] PAD_ZERO = 3'd2;
   localparam logic [2:0] LEN_HI   = 3'd3;
   localparam logic [2:0] LEN_LO   = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [63:0] bitcnt_q, bitcnt_d;
   logic [31:0] otpt_d_q, otpt_d_d;
   logic        otpt_vld_q, otpt_vld_d;
   logic        otpt_lst_q, otpt_lst_d;

   logic        out_free;
   logic        load;
   logic [31:0] word;
   logic        word_lst;
   logic [63:0] add_bits;

   // The output stage may take a new word when empty or when its word leaves this cycle.
   assign out_free   = !otpt_vld_q | pad_otpt_ena_i;
   assign msin_rdy_o = (state_q == DATA) & out_free & !rst;

   assign pad_otpt_d_o   = otpt_d_q;
   assign pad_otpt_vld_o = otpt_vld_q;
   assign pad_otpt_lst_o = otpt_lst_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      bitcnt_d   = bitcnt_q;
      otpt_d_d   = otpt_d_q;
      otpt_vld_d = otpt_vld_q;
      otpt_lst_d = otpt_lst_q;
      load       = 1'b0;
      word       = 32'h0;
      word_lst   = 1'b0;
      add_bits   = 64'd32;

      if (out_free) begin
         otpt_vld_d = 1'b0;
         otpt_lst_d = 1'b0;
         case (state_q)
            DATA: begin
               if (msin_vld_i) begin
                  load = 1'b1;
                  word = msin_d_i;
                  if (msin_lst_i) begin
                     if (msin_bcnt_i != 2'd0) begin
                        add_bits = {59'd0, msin_bcnt_i, 3'b000};
                        state_d  = (idx_q == 4'd13) ? LEN_HI : PAD_ZERO;
                     end else begin
                        state_d = PAD_ONE;
                     end
                     case (msin_bcnt_i)
                        2'd1:    word = {msin_d_i[31:24], 8'h80, 16'h0000};
                        2'd2:    word = {msin_d_i[31:16], 8'h80, 8'h00};
                        2'd3:    word = {msin_d_i[31:8], 8'h80};
                        default: word = msin_d_i;
                     endcase
                  end
                  bitcnt_d = bitcnt_q + add_bits;
               end
            end
            PAD_ONE: begin
               load    = 1'b1;
               word    = 32'h8000_0000;
               state_d = (idx_q == 4'd13) ? LEN_HI : PAD_ZERO;
            end
            PAD_ZERO: begin
               // Zero fill may wrap into a further block when the marker landed at index 14/15.
               load = 1'b1;
               word = 32'h0;
               if (idx_q == 4'd13) begin
                  state_d = LEN_HI;
               end
            end
            LEN_HI: begin
               load    = 1'b1;
               word    = bitcnt_q[63:32];
               state_d = LEN_LO;
            end
            LEN_LO: begin
               load     = 1'b1;
               word     = bitcnt_q[31:0];
               word_lst = 1'b1;
               bitcnt_d = 64'd0;
               state_d  = DATA;
            end
            default: begin
               state_d = DATA;
            end
         endcase
      end

      if (load) begin
         otpt_d_d   = word;
         otpt_vld_d = 1'b1;
         otpt_lst_d = word_lst;
         idx_d      = idx_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DATA;
         idx_q      <= 4'd0;
         bitcnt_q   <= 64'd0;
         otpt_d_q   <= 32'h0;
         otpt_vld_q <= 1'b0;
         otpt_lst_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         bitcnt_q   <= bitcnt_d;
         otpt_d_q   <= otpt_d_d;
         otpt_vld_q <= otpt_vld_d;
         otpt_lst_q <= otpt_lst_d;
      end
   end

endmodule
